// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, with a start/done handshake.
// The datapath is a full adder built from two half adders and an OR, with the carry held in a flop.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;

  always_comb begin
    ha1_s = a_sr_q[0] ^ b_sr_q[0];
    ha1_c = a_sr_q[0] & b_sr_q[0];
    ha2_s = ha1_s ^ c_q;
    ha2_c = ha1_s & c_q;
    fa_c  = ha1_c | ha2_c;
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    ps_d    = ps_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        ps_d   = {ha2_s, ps_q[WIDTH-1:1]};
        c_d    = fa_c;
        // Counter is held on the last bit so it never wraps when WIDTH is a power of two.
        if (cnt_q == LAST) begin
          sum_d   = {ha2_s, ps_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      ps_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      ps_q    <= ps_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder: handshake timing, result hold, mid-run start/reset, back-to-back issue.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   exp;
    logic         poke;
  } vec_t;

  vec_t vecs[10];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [W:0]  prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One operation: start for one cycle, scramble operands while running, optionally
  // re-pulse start during RUN and DONE; check busy/done per cycle, sum hold, and result.
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic [W:0] exp, input logic poke);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    for (int unsigned i = 0; i <= W + 1; i++) begin
      @(negedge clk);
      check("busy", {31'b0, busy}, {31'b0, (i <= W)});
      check("done", {31'b0, done}, {31'b0, (i == W)});
      if (i < W) check("sum_hold", {23'b0, cout, sum}, {23'b0, prev});
      if (i == W) check("result", {23'b0, cout, sum}, {23'b0, exp});
      start = poke && (i == 3 || i == W);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
    prev = exp;
  endtask

  logic [W:0]   pend;
  logic [W-1:0] cur_a, cur_b;
  logic         cur_c;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b0, 9'h000, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0};
    vecs[3] = '{8'h3C, 8'h42, 1'b0, 9'h07E, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 9'h046, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1};
    vecs[7] = '{8'h01, 8'h02, 1'b1, 9'h004, 1'b0};
    vecs[8] = '{8'h7F, 8'h00, 1'b1, 9'h080, 1'b0};
    vecs[9] = '{8'h55, 8'hAA, 1'b0, 9'h0FF, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sum", {23'b0, cout, sum}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) do_op(vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].exp, vecs[k].poke);

    // Reset asserted on the edge that would process bit 4.
    @(negedge clk);
    a = 8'hC3; b = 8'h3C; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    for (int unsigned i = 0; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_sum", {23'b0, cout, sum}, 32'd0);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      check("postrst_done", {31'b0, done}, 32'd0);
      check("postrst_busy", {31'b0, busy}, 32'd0);
    end
    prev = '0;
    do_op(8'h0F, 8'hF1, 1'b0, 9'h100, 1'b0);

    // start held high: accepts every W+2 edges starting at the first edge.
    @(negedge clk);
    start = 1'b1;
    cur_a = W'($urandom); cur_b = W'($urandom); cur_c = 1'($urandom);
    a = cur_a; b = cur_b; cin = cur_c;
    pend = '0;
    for (int unsigned j = 0; j < 1000 * (W + 2); j++) begin
      @(posedge clk);
      if (j % (W + 2) == 0) pend = {1'b0, cur_a} + {1'b0, cur_b} + {{W{1'b0}}, cur_c};
      @(negedge clk);
      check("bb_done", {31'b0, done}, {31'b0, (j % (W + 2) == W)});
      if (j % (W + 2) == W) check("bb_result", {23'b0, cout, sum}, {23'b0, pend});
      cur_a = W'($urandom); cur_b = W'($urandom); cur_c = 1'($urandom);
      a = cur_a; b = cur_b; cin = cur_c;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("end_idle", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
